// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types for the fetch stage
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    REDIR_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory port (req/gnt address phase, rvalid data phase)
interface if_stage_if;
  import core_pkg::*;

  logic            instr_req;
  logic [XLEN-1:0] instr_addr;
  logic            instr_gnt;
  logic            instr_rvalid;
  logic [XLEN-1:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata
  );

endinterface

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - prefetch buffer of {pc, instr} entries with synchronous clear
module prefetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output fetch_entry_t               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with prefetch FIFO and IF/ID register
module if_stage
  import core_pkg::*;
#(
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            set_pc_valid,
  input  logic [XLEN-1:0] set_pc,
  input  logic            stall_if_stage,
  input  logic            flush_if,
  if_stage_if.master      imem,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_addr;
  logic [XLEN-1:0] r_pending_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_instr;
  logic [XLEN-1:0] r_id_pc;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_inflight;
  logic            w_req;
  logic            w_fire;
  logic            w_rvalid;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_discard_dec;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;

  assign w_redirect = set_pc_valid && (r_state != BOOT);
  assign w_target   = set_pc & ~32'h3;
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  // A request stuck in REDIR_WAIT must stay asserted until it is granted
  assign w_req      = (r_state == REDIR_WAIT) || ((r_state == RUN) && (w_inflight < DEPTH_W));
  assign w_fire     = w_req && imem.instr_gnt;
  assign w_rvalid   = imem.instr_rvalid && (r_outstanding != '0);
  assign w_push     = w_rvalid && !w_redirect && (r_discard == '0);
  assign w_pop      = !flush_if && !stall_if_stage && !w_empty;
  assign w_out_next = r_outstanding + CW'(w_fire) - CW'(w_rvalid);
  assign w_discard_dec = r_discard - CW'(w_rvalid && (r_discard != '0));

  assign w_push_data.pc    = r_resp_pc;
  assign w_push_data.instr = imem.instr_rdata;

  assign imem.instr_req  = w_req;
  assign imem.instr_addr = r_fetch_addr;

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;

  prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= BOOT;
      r_fetch_addr  <= RESET_PC;
      r_pending_pc  <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
      if (r_state == BOOT) begin
        r_state <= RUN;
      end else if (w_redirect) begin
        // Everything in flight now belongs to the old path, including a grant this cycle
        r_discard <= w_out_next;
        r_resp_pc <= w_target;
        if (w_req && !imem.instr_gnt) begin
          r_pending_pc <= w_target;
          r_state      <= REDIR_WAIT;
        end else begin
          r_fetch_addr <= w_target;
          r_state      <= RUN;
        end
      end else if (r_state == REDIR_WAIT) begin
        r_discard <= w_discard_dec + CW'(w_fire);
        if (w_fire) begin
          r_fetch_addr <= r_pending_pc;
          r_state      <= RUN;
        end
      end else begin
        r_discard <= w_discard_dec;
        if (w_fire) r_fetch_addr <= r_fetch_addr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
    end else if (flush_if) begin
      r_id_valid <= 1'b0;
    end else if (!stall_if_stage) begin
      r_id_valid <= !w_empty;
      if (!w_empty) begin
        r_id_instr <= w_head.instr;
        r_id_pc    <= w_head.pc;
      end
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(w_push && w_full));

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage
module tb_if_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_pc_valid;
  logic [31:0] set_pc;
  logic        stall_if_stage;
  logic        flush_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_stage_if imem ();

  if_stage #(
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .set_pc_valid   (set_pc_valid),
    .set_pc         (set_pc),
    .stall_if_stage (stall_if_stage),
    .flush_if       (flush_if),
    .imem           (imem),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spv;
    logic [31:0] spc;
    logic        stall;
    logic        flush;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          failures = 0;
  logic        pend_v;
  logic [31:0] pend_d;
  logic [31:0] pc0;
  logic [31:0] fires[$];
  logic [31:0] loads[$];

  function automatic vec_t mk(input logic spv, input logic [31:0] spc, input logic stall,
                              input logic flush, input logic gnt, input logic rv,
                              input logic [31:0] rd, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.spv = spv; v.spc = spc; v.stall = stall; v.flush = flush; v.gnt = gnt; v.rv = rv;
    v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_instr;
    return v;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_pc_valid = 1'b0; set_pc = '0; stall_if_stage = 1'b0; flush_if = 1'b0;
    imem.instr_gnt = 1'b0; imem.instr_rvalid = 1'b0; imem.instr_rdata = '0;
    pend_v = 1'b0; pend_d = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One cycle of a memory that answers every grant on the following cycle
  task automatic step(input logic g);
    imem.instr_gnt    = g;
    imem.instr_rvalid = pend_v;
    imem.instr_rdata  = pend_v ? pend_d : 32'hDEAD_BEEF;
    pend_v = imem.instr_req && g;
    pend_d = word(imem.instr_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_load(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (!id_valid && n < 20);
    chk({name, "_valid"}, 32'(id_valid), 32'd1);
    chk({name, "_pc"}, id_pc, exp_pc);
    chk({name, "_instr"}, id_instr, word(exp_pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            0, 32'h000, 0, 32'h000, NOP_INSTR));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h000, 0, 32'h000, NOP_INSTR));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA000_0000, 1, 32'h004, 0, 32'h000, NOP_INSTR));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA000_0004, 0, 32'h008, 0, 32'h000, NOP_INSTR));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h008, 1, 32'h000, 32'hA000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA000_0008, 1, 32'h00C, 1, 32'h004, 32'hA000_0004));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h00C, 0, 32'h004, 32'hA000_0004));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h00C, 1, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h00C, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h010, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(1, 32'h103, 0, 0, 1, 0, 0,      0, 32'h014, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hBAD0_0001, 0, 32'h100, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hBAD0_0002, 1, 32'h100, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC000_0100, 1, 32'h104, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h104, 0, 32'h008, 32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h104, 1, 32'h100, 32'hC000_0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h104, 0, 32'h100, 32'hC000_0100));

    do_reset();
    foreach (tbl[i]) begin
      chk($sformatf("row%0d_req", i), 32'(imem.instr_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_addr", i), imem.instr_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(id_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d_pc", i), id_pc, tbl[i].e_pc);
      chk($sformatf("row%0d_instr", i), id_instr, tbl[i].e_instr);
      set_pc_valid      = tbl[i].spv;
      set_pc            = tbl[i].spc;
      stall_if_stage    = tbl[i].stall;
      flush_if          = tbl[i].flush;
      imem.instr_gnt    = tbl[i].gnt;
      imem.instr_rvalid = tbl[i].rv;
      imem.instr_rdata  = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
    end
    set_pc_valid = 1'b0;

    // Request held without grant for five cycles
    do_reset();
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_req", i), 32'(imem.instr_req), 32'd1);
      chk($sformatf("hold%0d_addr", i), imem.instr_addr, 32'h0);
      step(1'b0);
    end
    chk("hold_idle_valid", 32'(id_valid), 32'd0);
    step(1'b1);
    chk("hold_after_gnt_addr", imem.instr_addr, 32'h4);

    // Redirect while the request for 0x8 waits for its grant
    for (int i = 0; i < 20 && !(imem.instr_req && imem.instr_addr == 32'h8); i++) step(1'b1);
    chk("redir_reach_req8", 32'(imem.instr_req && imem.instr_addr == 32'h8), 32'd1);
    set_pc_valid = 1'b1; set_pc = 32'h0000_0203; flush_if = 1'b1;
    step(1'b0);
    set_pc_valid = 1'b0; flush_if = 1'b0;
    chk("redir_hold_req", 32'(imem.instr_req), 32'd1);
    chk("redir_hold_addr", imem.instr_addr, 32'h8);
    chk("redir_flush_valid", 32'(id_valid), 32'd0);
    step(1'b0);
    chk("redir_hold2_addr", imem.instr_addr, 32'h8);
    step(1'b1);
    chk("redir_new_addr", imem.instr_addr, 32'h200);
    wait_load("redir_ld0", 32'h200);
    wait_load("redir_ld1", 32'h204);

    // Stall the IF/ID register while the FIFO fills
    pc0 = id_pc;
    stall_if_stage = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk($sformatf("stall%0d_pc", i), id_pc, pc0);
      chk($sformatf("stall%0d_valid", i), 32'(id_valid), 32'd1);
    end
    chk("stall_req_dropped", 32'(imem.instr_req), 32'd0);
    stall_if_stage = 1'b0;
    wait_load("stall_rel0", pc0 + 32'd4);
    wait_load("stall_rel1", pc0 + 32'd8);
    wait_load("stall_rel2", pc0 + 32'd12);

    // Flush with stall keeps FIFO contents
    pc0 = id_pc;
    stall_if_stage = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    flush_if = 1'b1;
    step(1'b1);
    chk("flush_valid", 32'(id_valid), 32'd0);
    flush_if = 1'b0; stall_if_stage = 1'b0;
    step(1'b1);
    chk("flush_next_valid", 32'(id_valid), 32'd1);
    chk("flush_next_pc", id_pc, pc0 + 32'd4);

    // Fetch address wraps at the top of the address space
    set_pc_valid = 1'b1; set_pc = 32'hFFFF_FFFB; flush_if = 1'b1;
    step(1'b1);
    set_pc_valid = 1'b0; flush_if = 1'b0;
    for (int i = 0; i < 30 && loads.size() < 3; i++) begin
      if (imem.instr_req && fires.size() < 3) fires.push_back(imem.instr_addr);
      step(1'b1);
      if (id_valid) begin
        loads.push_back(id_pc);
        chk($sformatf("wrap_ld%0d_instr", loads.size() - 1), id_instr, word(id_pc));
      end
    end
    chk("wrap_nfires", 32'(fires.size()), 32'd3);
    chk("wrap_nloads", 32'(loads.size()), 32'd3);
    if (fires.size() == 3) begin
      chk("wrap_fire0", fires[0], 32'hFFFF_FFF8);
      chk("wrap_fire1", fires[1], 32'hFFFF_FFFC);
      chk("wrap_fire2", fires[2], 32'h0000_0000);
    end
    if (loads.size() == 3) begin
      chk("wrap_ld0_pc", loads[0], 32'hFFFF_FFF8);
      chk("wrap_ld1_pc", loads[1], 32'hFFFF_FFFC);
      chk("wrap_ld2_pc", loads[2], 32'h0000_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
